pong_game_ctrl: RTL and testbench
=================================

// Module: pong_game_ctrl
// PURPOSE
//  Parametrised game-flow controller for vPong. It replaces the fixed frame divider, restart and pause glue in the top level.
//  Generates the per-frame movement tick with a speed ramp, a serve delay, pause/resume,
//  per-player score counting, win detection and game restart for NPLAYERS players.
//  Sits between the VGA timing block (frame_start) and the ball/bar movers and score displays.
// PARAMETERS
//  NPLAYERS     2    number of players / score channels (1..4)
//  SCORE_W      4    width of each score counter
//  WIN_SCORE    9    score that ends the game (< 2**SCORE_W)
//  SPEED_START  12   frames per tick at serve (initial period)
//  SPEED_MIN    3    fastest allowed period, frames per tick (>=1, <=SPEED_START)
//  RAMP_FRAMES  600  PLAY frames between period decrements
//  SERVE_FRAMES 60   frames held in SERVE before PLAY
//  CNT_W        10   width of internal frame counters (must hold RAMP_FRAMES, SERVE_FRAMES)
// PORTS
//  ClockK      in   1                  pixel clock, all logic on rising edge
//  reset       in   1                  asynchronous, active-high
//  frame_start in   1                  1-cycle pulse at start of vertical sync
//  pause_btn   in   1                  raw pause button, asynchronous to ClockK
//  point_evt   in   NPLAYERS           1-cycle pulse, bit i = player i scored
//  tick        out  1                  1-cycle movement enable for ball/bars
//  restart     out  1                  1-cycle pulse: re-centre ball
//  score       out  NPLAYERS*SCORE_W   player i at [i*SCORE_W +: SCORE_W]
//  winner      out  NPLAYERS           one-hot winner, valid in GAMEOVER
//  state       out  2                  0 SERVE, 1 PLAY, 2 PAUSED, 3 GAMEOVER
// BEHAVIOUR
//  Reset: state=SERVE, tick=0, restart=0, score=0, winner=0, period=SPEED_START, all counters 0.
//  First cycle after reset deassert: restart=1 for exactly one cycle.
//  pause_btn: 2-FF synchroniser, then rising-edge detect -> pause_edge (1 cycle). Input-to-edge latency 3 cycles.
//  All outputs registered. tick/restart are asserted the cycle after the causing event.
//  SERVE: count frame_start pulses.
//    - After SERVE_FRAMES pulses: go to PLAY with frame_cnt=0, ramp_cnt=0.
//    - No ticks in SERVE.
//  PLAY: on each frame_start:
//    - If frame_cnt==period-1: frame_cnt=0 and tick=1 next cycle. Otherwise frame_cnt++.
//    - ramp_cnt++. At RAMP_FRAMES: ramp_cnt=0 and period-- if period>SPEED_MIN. period saturates at SPEED_MIN.
//  Point (PLAY only; point_evt ignored in all other states):
//    - Lowest set index i wins; the other set bits in the same cycle are dropped.
//    - score[i]++. restart=1 next cycle. period=SPEED_START. Serve counter cleared.
//    - If the new score[i]==WIN_SCORE: go to GAMEOVER and set winner[i]. Otherwise go to SERVE.
//  Pause:
//    - pause_edge in SERVE or PLAY: go to PAUSED and remember the return state.
//    - pause_edge in PAUSED: return to the saved state. frame_cnt, ramp_cnt, serve count and period are all retained.
//    - In PAUSED, frame_start does not advance any counter. No tick.
//  GAMEOVER: scores and winner held, no tick. On pause_edge:
//    - score=0, winner=0, period=SPEED_START.
//    - restart=1 next cycle. Go to SERVE.
//  Simultaneous events:
//    - point_evt and pause_edge in the same PLAY cycle: the point is processed and the pause is dropped.
//    - frame_start together with a point: the point wins and that frame's tick is suppressed.
//  Scores never exceed WIN_SCORE.
//  Reset asserted mid-game: immediate return to reset values.
//  Widths: period has width CNT_W. Comparisons are unsigned.
// TESTING
//  T1 reset release:
//    - restart pulses once at cycle 1, state=SERVE.
//    - After 60 frame_start pulses, state=PLAY.
//    - Ticks appear every 12 frames, each 1 cycle wide.
//  T2 ramp:
//    - Hold PLAY for 600*10 frames.
//    - Period steps 12->11->...->3 and stays at 3; tick spacing is measured per step.
//  T3 scoring and win:
//    - Nine point_evt=2'b10 pulses, each followed by a serve.
//    - score1 reaches 9, state=3, winner=2'b10, score0=0.
//    - Further point_evt pulses have no effect.
//  T4 pause:
//    - pause_btn pulse at PLAY frame_cnt=5 -> PAUSED.
//    - 50 frames pass: no tick, counters frozen.
//    - Second pause pulse -> PLAY; the next tick arrives 7 frames later.
//  T5 collisions:
//    - point_evt=2'b11 -> only score0 increments.
//    - point_evt together with pause_edge -> state=SERVE, not PAUSED.
//    - point_evt during SERVE -> ignored.
//  T6 GAMEOVER restart and async reset:
//    - pause in GAMEOVER -> scores 0, restart pulse, SERVE.
//    - reset asserted mid-PLAY -> all outputs zero within the same cycle.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// Game-flow controller for vPong: serve delay, movement tick with speed ramp,
// pause/resume, per-player scoring, win detection and restart.
module pong_game_ctrl #(
  parameter int NPLAYERS     = 2,
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 9,
  parameter int SPEED_START  = 12,
  parameter int SPEED_MIN    = 3,
  parameter int RAMP_FRAMES  = 600,
  parameter int SERVE_FRAMES = 60,
  parameter int CNT_W        = 10
) (
  input  logic                          ClockK,
  input  logic                          reset,
  input  logic                          frame_start,
  input  logic                          pause_btn,
  input  logic [NPLAYERS-1:0]           point_evt,
  output logic                          tick,
  output logic                          restart,
  output logic [NPLAYERS*SCORE_W-1:0]   score,
  output logic [NPLAYERS-1:0]           winner,
  output logic [1:0]                    state
);

  typedef enum logic [1:0] {
    S_SERVE  = 2'd0,
    S_PLAY   = 2'd1,
    S_PAUSED = 2'd2,
    S_OVER   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]   PERIOD_INIT = CNT_W'(SPEED_START);
  localparam logic [CNT_W-1:0]   PERIOD_MIN  = CNT_W'(SPEED_MIN);
  localparam logic [CNT_W-1:0]   RAMP_LAST   = CNT_W'(RAMP_FRAMES - 1);
  localparam logic [CNT_W-1:0]   SERVE_LAST  = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL     = SCORE_W'(WIN_SCORE);

  state_t state_reg, state_next;
  state_t ret_reg, ret_next;
  logic [CNT_W-1:0] frame_cnt_reg, frame_cnt_next;
  logic [CNT_W-1:0] ramp_cnt_reg, ramp_cnt_next;
  logic [CNT_W-1:0] serve_cnt_reg, serve_cnt_next;
  logic [CNT_W-1:0] period_reg, period_next;
  logic [NPLAYERS*SCORE_W-1:0] score_reg, score_next;
  logic [NPLAYERS-1:0] winner_reg, winner_next;
  logic tick_reg, tick_next;
  logic restart_reg, restart_next;
  logic first_reg;
  logic pb_meta_reg, pb_sync_reg, pb_prev_reg, pause_edge_reg;

  logic [NPLAYERS-1:0] point_sel;
  logic [NPLAYERS-1:0] win_now;
  logic [SCORE_W-1:0]  score_inc [NPLAYERS];
  logic                point_hit;

  // Isolate the lowest-index scorer; simultaneous higher-index points are dropped.
  assign point_sel = point_evt & (~point_evt + 1'b1);
  assign point_hit = |point_evt;

  genvar gi;
  generate
    for (gi = 0; gi < NPLAYERS; gi++) begin : g_player
      assign score_inc[gi] = score_reg[gi*SCORE_W +: SCORE_W] + 1'b1;
      assign win_now[gi]   = (score_inc[gi] == WIN_VAL);
    end
  endgenerate

  always_ff @(posedge ClockK or posedge reset) begin
    if (reset) begin
      pb_meta_reg    <= 1'b0;
      pb_sync_reg    <= 1'b0;
      pb_prev_reg    <= 1'b0;
      pause_edge_reg <= 1'b0;
    end else begin
      pb_meta_reg    <= pause_btn;
      pb_sync_reg    <= pb_meta_reg;
      pb_prev_reg    <= pb_sync_reg;
      pause_edge_reg <= pb_sync_reg & ~pb_prev_reg;
    end
  end

  always_ff @(posedge ClockK or posedge reset) begin
    if (reset) begin
      state_reg     <= S_SERVE;
      ret_reg       <= S_SERVE;
      frame_cnt_reg <= '0;
      ramp_cnt_reg  <= '0;
      serve_cnt_reg <= '0;
      period_reg    <= PERIOD_INIT;
      score_reg     <= '0;
      winner_reg    <= '0;
      tick_reg      <= 1'b0;
      restart_reg   <= 1'b0;
      first_reg     <= 1'b1;
    end else begin
      state_reg     <= state_next;
      ret_reg       <= ret_next;
      frame_cnt_reg <= frame_cnt_next;
      ramp_cnt_reg  <= ramp_cnt_next;
      serve_cnt_reg <= serve_cnt_next;
      period_reg    <= period_next;
      score_reg     <= score_next;
      winner_reg    <= winner_next;
      tick_reg      <= tick_next;
      restart_reg   <= restart_next;
      first_reg     <= 1'b0;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ret_next       = ret_reg;
    frame_cnt_next = frame_cnt_reg;
    ramp_cnt_next  = ramp_cnt_reg;
    serve_cnt_next = serve_cnt_reg;
    period_next    = period_reg;
    score_next     = score_reg;
    winner_next    = winner_reg;
    tick_next      = 1'b0;
    restart_next   = first_reg;

    case (state_reg)
      S_SERVE: begin
        if (pause_edge_reg) begin
          ret_next   = S_SERVE;
          state_next = S_PAUSED;
        end else if (frame_start) begin
          if (serve_cnt_reg == SERVE_LAST) begin
            state_next     = S_PLAY;
            serve_cnt_next = '0;
            frame_cnt_next = '0;
            ramp_cnt_next  = '0;
          end else begin
            serve_cnt_next = serve_cnt_reg + 1'b1;
          end
        end
      end

      S_PLAY: begin
        if (point_hit) begin
          restart_next   = 1'b1;
          period_next    = PERIOD_INIT;
          serve_cnt_next = '0;
          state_next     = S_SERVE;
          for (int i = 0; i < NPLAYERS; i++) begin
            if (point_sel[i]) begin
              score_next[i*SCORE_W +: SCORE_W] = score_inc[i];
              if (win_now[i]) begin
                winner_next[i] = 1'b1;
                state_next     = S_OVER;
              end
            end
          end
        end else if (pause_edge_reg) begin
          ret_next   = S_PLAY;
          state_next = S_PAUSED;
        end else if (frame_start) begin
          // >= keeps the divider in range when a ramp step shortens the period
          // while frame_cnt already sits at the new limit.
          if (frame_cnt_reg >= period_reg - 1'b1) begin
            frame_cnt_next = '0;
            tick_next      = 1'b1;
          end else begin
            frame_cnt_next = frame_cnt_reg + 1'b1;
          end
          if (ramp_cnt_reg == RAMP_LAST) begin
            ramp_cnt_next = '0;
            if (period_reg > PERIOD_MIN) begin
              period_next = period_reg - 1'b1;
            end
          end else begin
            ramp_cnt_next = ramp_cnt_reg + 1'b1;
          end
        end
      end

      S_PAUSED: begin
        if (pause_edge_reg) begin
          state_next = ret_reg;
        end
      end

      default: begin
        if (pause_edge_reg) begin
          score_next     = '0;
          winner_next    = '0;
          period_next    = PERIOD_INIT;
          serve_cnt_next = '0;
          restart_next   = 1'b1;
          state_next     = S_SERVE;
        end
      end
    endcase
  end

  assign tick    = tick_reg;
  assign restart = restart_reg;
  assign score   = score_reg;
  assign winner  = winner_reg;
  assign state   = state_reg;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: frame-level reference model feeding a
// scoreboard queue, plus per-scenario directed checks.
module tb_pong_game_ctrl;
  localparam int NP      = 2;
  localparam int SW      = 4;
  localparam int SERVE_F = 60;
  localparam int RAMP_F  = 600;
  localparam int P_START = 12;
  localparam int P_MIN   = 3;
  localparam int WIN     = 9;

  logic ClockK = 1'b0;
  logic reset = 1'b1;
  logic frame_start = 1'b0;
  logic pause_btn = 1'b0;
  logic [NP-1:0] point_evt = '0;
  logic tick, restart;
  logic [NP*SW-1:0] score;
  logic [NP-1:0] winner;
  logic [1:0] state;

  pong_game_ctrl #(
    .NPLAYERS(NP), .SCORE_W(SW), .WIN_SCORE(WIN), .SPEED_START(P_START),
    .SPEED_MIN(P_MIN), .RAMP_FRAMES(RAMP_F), .SERVE_FRAMES(SERVE_F), .CNT_W(10)
  ) dut (
    .ClockK(ClockK), .reset(reset), .frame_start(frame_start), .pause_btn(pause_btn),
    .point_evt(point_evt), .tick(tick), .restart(restart), .score(score),
    .winner(winner), .state(state)
  );

  always #5 ClockK = ~ClockK;

  typedef struct packed {
    logic            tick;
    logic            restart;
    logic [1:0]      state;
    logic [NP*SW-1:0] score;
    logic [NP-1:0]   winner;
  } obs_t;

  obs_t exp_q[$];
  int total = 0;
  int bad = 0;
  string cur_test = "init";

  // Reference model, advanced once per clock by step().
  int m_state, m_ret, m_frame, m_ramp, m_serve, m_period;
  int m_score[NP];
  logic [NP-1:0] m_win;
  logic m_first, m_tick, m_restart;

  function automatic void model_reset();
    m_state = 0; m_ret = 0; m_frame = 0; m_ramp = 0; m_serve = 0;
    m_period = P_START; m_win = '0; m_first = 1'b1;
    for (int i = 0; i < NP; i++) m_score[i] = 0;
  endfunction

  task automatic step(input logic fs, input logic [NP-1:0] pe, input logic pp);
    obs_t e;
    bit done;
    frame_start = fs;
    point_evt   = pe;
    m_tick    = 1'b0;
    m_restart = m_first;
    m_first   = 1'b0;
    case (m_state)
      0: begin
        if (pp) begin m_ret = 0; m_state = 2; end
        else if (fs) begin
          m_serve++;
          if (m_serve == SERVE_F) begin
            m_state = 1; m_serve = 0; m_frame = 0; m_ramp = 0;
          end
        end
      end
      1: begin
        if (pe != 0) begin
          done = 0;
          for (int i = 0; i < NP; i++) begin
            if (pe[i] && !done) begin
              done = 1;
              m_score[i]++;
              if (m_score[i] == WIN) begin m_win[i] = 1'b1; m_state = 3; end
              else m_state = 0;
            end
          end
          m_restart = 1'b1; m_period = P_START; m_serve = 0;
        end else if (pp) begin
          m_ret = 1; m_state = 2;
        end else if (fs) begin
          m_frame++;
          if (m_frame >= m_period) begin m_tick = 1'b1; m_frame = 0; end
          m_ramp++;
          if (m_ramp == RAMP_F) begin
            m_ramp = 0;
            if (m_period > P_MIN) m_period--;
          end
        end
      end
      2: if (pp) m_state = m_ret;
      default: begin
        if (pp) begin
          for (int i = 0; i < NP; i++) m_score[i] = 0;
          m_win = '0; m_period = P_START; m_serve = 0; m_restart = 1'b1; m_state = 0;
        end
      end
    endcase
    e.tick = m_tick;
    e.restart = m_restart;
    e.state = m_state[1:0];
    for (int i = 0; i < NP; i++) e.score[i*SW +: SW] = m_score[i][SW-1:0];
    e.winner = m_win;
    exp_q.push_back(e);
    @(posedge ClockK);
    @(negedge ClockK);
    frame_start = 1'b0;
    point_evt   = '0;
  endtask

  // Scoreboard: every step's expected outputs are compared 2 time units after the edge.
  always @(posedge ClockK) begin : monitor
    obs_t e, g;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {tick, restart, state, score, winner};
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL %s cycle: got tick=%0b restart=%0b state=%0d score=%h winner=%b, want tick=%0b restart=%0b state=%0d score=%h winner=%b",
                 cur_test, g.tick, g.restart, g.state, g.score, g.winner,
                 e.tick, e.restart, e.state, e.score, e.winner);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  task automatic serve();
    for (int i = 0; i < SERVE_F; i++) begin
      step(1'b1, '0, 1'b0);
      step(1'b0, '0, 1'b0);
    end
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, '0, 1'b0);
      step(1'b0, '0, 1'b0);
    end
  endtask

  // Button press; the synchronised edge reaches the FSM on the 4th clock.
  task automatic press(input logic [NP-1:0] pe, input logic fs,
                       output logic rs_seen, output logic [1:0] st_after);
    pause_btn = 1'b1;
    idle(3);
    step(fs, pe, 1'b1);
    rs_seen  = restart;
    st_after = state;
    pause_btn = 1'b0;
    idle(3);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge ClockK);
    @(negedge ClockK);
    reset = 1'b0;
    model_reset();
    step(1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    cur_test = "reset";
    repeat (3) @(negedge ClockK);
    total++;
    if ({tick, restart, state, score, winner} !== '0) begin
      bad++;
      $display("FAIL reset_values: got %h want 0", {tick, restart, state, score, winner});
    end
    reset = 1'b0;
    model_reset();
    step(1'b0, '0, 1'b0);
    total++;
    if (restart !== 1'b1) begin
      bad++;
      $display("FAIL reset_restart_pulse: got %0b want 1", restart);
    end
    step(1'b0, '0, 1'b0);
    total++;
    if (restart !== 1'b0) begin
      bad++;
      $display("FAIL reset_restart_width: got %0b want 0", restart);
    end
  endtask

  task automatic test_serve_play();
    int nt, first_t, last_t;
    cur_test = "serve_play";
    frames(SERVE_F - 1);
    total++;
    if (state !== 2'd0) begin
      bad++;
      $display("FAIL serve_hold: got state %0d want 0", state);
    end
    frames(1);
    total++;
    if (state !== 2'd1) begin
      bad++;
      $display("FAIL serve_to_play: got state %0d want 1", state);
    end
    nt = 0; first_t = 0; last_t = 0;
    for (int f = 1; f <= 36; f++) begin
      step(1'b1, '0, 1'b0);
      if (tick === 1'b1) begin
        nt++;
        if (first_t == 0) first_t = f;
        last_t = f;
      end
      step(1'b0, '0, 1'b0);
    end
    total++;
    if (nt != 3 || first_t != 12 || last_t != 36) begin
      bad++;
      $display("FAIL play_ticks: got count=%0d first=%0d last=%0d want 3/12/36", nt, first_t, last_t);
    end
  endtask

  task automatic test_ramp();
    int last_t[11];
    int prev_t[11];
    int w, want;
    cur_test = "ramp";
    do_reset();
    serve();
    for (int k = 0; k < 11; k++) begin last_t[k] = 0; prev_t[k] = 0; end
    for (int n = 1; n <= RAMP_F * 10 + 300; n++) begin
      step(1'b1, '0, 1'b0);
      if (tick === 1'b1) begin
        w = (n - 1) / RAMP_F;
        prev_t[w] = last_t[w];
        last_t[w] = n;
      end
      step(1'b0, '0, 1'b0);
    end
    for (int k = 0; k < 11; k++) begin
      want = (P_START - k > P_MIN) ? P_START - k : P_MIN;
      total++;
      if (last_t[k] - prev_t[k] != want) begin
        bad++;
        $display("FAIL ramp_spacing_step%0d: got %0d want %0d", k, last_t[k] - prev_t[k], want);
      end
    end
  endtask

  task automatic test_score_win();
    logic [NP*SW-1:0] s_hold;
    cur_test = "score_win";
    do_reset();
    serve();
    for (int p = 1; p <= WIN; p++) begin
      step(1'b0, 2'b10, 1'b0);
      total++;
      if (restart !== 1'b1 || state !== ((p < WIN) ? 2'd0 : 2'd3)) begin
        bad++;
        $display("FAIL point%0d: got restart=%0b state=%0d want 1/%0d", p, restart, state, (p < WIN) ? 0 : 3);
      end
      if (p < WIN) serve();
    end
    total++;
    if (score !== 8'h90 || winner !== 2'b10) begin
      bad++;
      $display("FAIL win: got score=%h winner=%b want 90/10", score, winner);
    end
    s_hold = score;
    step(1'b0, 2'b01, 1'b0);
    step(1'b0, 2'b10, 1'b0);
    step(1'b1, 2'b11, 1'b0);
    total++;
    if (score !== 8'h90 || state !== 2'd3 || tick !== 1'b0) begin
      bad++;
      $display("FAIL gameover_hold: got score=%h state=%0d tick=%0b want %h/3/0", score, state, tick, s_hold);
    end
  endtask

  task automatic test_gameover_restart();
    logic rs;
    logic [1:0] st;
    cur_test = "gameover_restart";
    press('0, 1'b0, rs, st);
    total++;
    if (rs !== 1'b1 || st !== 2'd0 || score !== '0 || winner !== '0) begin
      bad++;
      $display("FAIL gameover_restart: got restart=%0b state=%0d score=%h winner=%b want 1/0/0/0", rs, st, score, winner);
    end
  endtask

  task automatic test_pause();
    logic rs;
    logic [1:0] st;
    int nt, f_tick;
    cur_test = "pause";
    serve();
    frames(5);
    press('0, 1'b0, rs, st);
    total++;
    if (st !== 2'd2) begin
      bad++;
      $display("FAIL pause_enter: got state %0d want 2", st);
    end
    nt = 0;
    for (int f = 0; f < 50; f++) begin
      step(1'b1, '0, 1'b0);
      if (tick === 1'b1) nt++;
      step(1'b0, '0, 1'b0);
    end
    total++;
    if (nt != 0 || state !== 2'd2) begin
      bad++;
      $display("FAIL paused_frozen: got ticks=%0d state=%0d want 0/2", nt, state);
    end
    press('0, 1'b0, rs, st);
    total++;
    if (st !== 2'd1) begin
      bad++;
      $display("FAIL pause_resume: got state %0d want 1", st);
    end
    f_tick = 0;
    for (int f = 1; f <= 20 && f_tick == 0; f++) begin
      step(1'b1, '0, 1'b0);
      if (tick === 1'b1) f_tick = f;
      step(1'b0, '0, 1'b0);
    end
    total++;
    if (f_tick != 7) begin
      bad++;
      $display("FAIL resume_tick_delay: got %0d frames want 7", f_tick);
    end
  endtask

  task automatic test_collisions();
    logic rs;
    logic [1:0] st;
    logic [NP*SW-1:0] s0;
    cur_test = "collisions";
    s0 = score;
    step(1'b0, 2'b11, 1'b0);
    total++;
    if (score !== s0 + 8'h01 || state !== 2'd0) begin
      bad++;
      $display("FAIL dual_point: got score=%h state=%0d want %h/0", score, state, s0 + 8'h01);
    end
    s0 = score;
    step(1'b0, 2'b01, 1'b0);
    total++;
    if (score !== s0 || restart !== 1'b0) begin
      bad++;
      $display("FAIL serve_point_ignored: got score=%h restart=%0b want %h/0", score, restart, s0);
    end
    serve();
    s0 = score;
    press(2'b10, 1'b0, rs, st);
    total++;
    if (st !== 2'd0 || rs !== 1'b1 || score !== s0 + 8'h10) begin
      bad++;
      $display("FAIL point_with_pause: got state=%0d restart=%0b score=%h want 0/1/%h", st, rs, score, s0 + 8'h10);
    end
    serve();
    frames(P_START - 1);
    step(1'b1, 2'b01, 1'b0);
    total++;
    if (tick !== 1'b0 || state !== 2'd0) begin
      bad++;
      $display("FAIL frame_with_point: got tick=%0b state=%0d want 0/0", tick, state);
    end
  endtask

  task automatic test_async_reset();
    cur_test = "async_reset";
    serve();
    frames(4);
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({tick, restart, state, score, winner} !== '0) begin
      bad++;
      $display("FAIL async_reset: got %h want 0", {tick, restart, state, score, winner});
    end
    @(negedge ClockK);
    @(negedge ClockK);
    reset = 1'b0;
    model_reset();
    step(1'b0, '0, 1'b0);
    total++;
    if (restart !== 1'b1 || state !== 2'd0) begin
      bad++;
      $display("FAIL post_reset_restart: got restart=%0b state=%0d want 1/0", restart, state);
    end
    idle(2);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_serve_play();
    test_ramp();
    test_score_win();
    test_gameover_restart();
    test_pause();
    test_collisions();
    test_async_reset();
    repeat (3) @(negedge ClockK);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
